// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: IF-stage program counter with branch/jump resolution, a stall-safe
// pending-redirect latch and a sticky misalignment flag. Define PC_FETCH_RAS_EN for the return-address stack.
module pc_fetch_ctrl #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       pcenable,
  input  logic [1:0]                 pcsrc,
  input  logic                       BEQ,
  input  logic                       zero_f,
  input  logic [PC_W-1:0]            branch_pc4,
  input  logic [PC_W-1:0]            immedEXT,
  input  logic [25:0]                jaddr,
  input  logic [PC_W-1:0]            rdat1,
  input  logic                       jr_ra,
  input  logic                       ras_push,
  output logic [PC_W-1:0]            pcout,
  output logic [PC_W-1:0]            pcplus4,
  output logic                       redirect,
  output logic                       pend_valid,
  output logic                       misalign,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

  localparam logic [1:0] SRC_SEQ = 2'b00;
  localparam logic [1:0] SRC_JR  = 2'b01;
  localparam logic [1:0] SRC_BR  = 2'b10;
  localparam logic [1:0] SRC_J   = 2'b11;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return a & ~PC_W'(3);
  endfunction

  function automatic logic is_misaligned(input logic [PC_W-1:0] a);
    return |a[1:0];
  endfunction

  logic                   br_taken;
  logic signed [PC_W-1:0] br_off;
  logic [PC_W-1:0]        br_tgt;
  logic [PC_W-1:0]        j_tgt;
  logic                   req_valid;
  logic                   req_pop;
  logic [PC_W-1:0]        req_tgt;
  logic                   ras_hit;
  logic [PC_W-1:0]        ras_top;
  logic [PC_W-1:0]        pend_tgt_p0;
  logic [PC_W-1:0]        pc_nxt;
  logic                   redir_nxt;

  assign pcplus4  = pcout + PC_W'(4);
  assign br_taken = (BEQ & zero_f) | (~BEQ & ~zero_f);
  assign br_off   = $signed(immedEXT) <<< 2;
  assign br_tgt   = branch_pc4 + $unsigned(br_off);
  assign j_tgt    = {pcplus4[PC_W-1:28], jaddr, 2'b00};

  // Redirect request decode for the instruction presented this cycle.
  always_comb begin
    req_valid = 1'b0;
    req_pop   = 1'b0;
    req_tgt   = pcplus4;
    case (pcsrc)
      SRC_SEQ: ;
      SRC_JR: begin
        req_valid = 1'b1;
        req_tgt   = ras_hit ? ras_top : rdat1;
        req_pop   = ras_hit;
      end
      SRC_BR: begin
        if (br_taken) begin
          req_valid = 1'b1;
          req_tgt   = br_tgt;
        end
      end
      SRC_J: begin
        req_valid = 1'b1;
        req_tgt   = j_tgt;
      end
      default: ;
    endcase
  end

  // A latched redirect takes priority over anything arriving alongside it.
  always_comb begin
    pc_nxt    = pcplus4;
    redir_nxt = 1'b0;
    if (pend_valid) begin
      pc_nxt    = pend_tgt_p0;
      redir_nxt = 1'b1;
    end else if (req_valid) begin
      pc_nxt    = req_tgt;
      redir_nxt = 1'b1;
    end
  end

  // Stage p0: PC register and pending-redirect latch.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pcout       <= RESET_PC;
      redirect    <= 1'b0;
      pend_valid  <= 1'b0;
      pend_tgt_p0 <= '0;
      misalign    <= 1'b0;
    end else if (pcenable) begin
      pcout      <= align_pc(pc_nxt);
      redirect   <= redir_nxt;
      pend_valid <= 1'b0;
      if (is_misaligned(pc_nxt))
        misalign <= 1'b1;
    end else begin
      redirect <= 1'b0;
      if (req_valid) begin
        pend_valid  <= 1'b1;
        pend_tgt_p0 <= req_tgt;
      end
    end
  end

`ifdef PC_FETCH_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [CNT_W-1:0] ras_cnt;
  logic             pend_pop_p0;
  logic             ras_do_push;
  logic             ras_do_pop;

  assign ras_hit     = jr_ra && (ras_cnt != '0);
  assign ras_top     = ras_mem[ras_ptr - PTR_W'(1)];
  assign ras_do_pop  = pcenable && (pend_valid ? pend_pop_p0 : req_pop);
  assign ras_do_push = pcenable && !pend_valid && ras_push;
  assign ras_count   = ras_cnt;

  // A RAS-predicted target latched during a stall pops only when it is applied.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      pend_pop_p0 <= 1'b0;
    else if (pcenable)
      pend_pop_p0 <= 1'b0;
    else if (req_valid)
      pend_pop_p0 <= req_pop;
  end

  // ras_ptr points at the next free slot; when full it also points at the oldest entry.
  always_ff @(posedge CLK) begin
    if (ras_do_push) begin
      if (ras_do_pop)
        ras_mem[ras_ptr - PTR_W'(1)] <= branch_pc4;
      else
        ras_mem[ras_ptr] <= branch_pc4;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_do_push && !ras_do_pop) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (ras_cnt != CNT_W'(RAS_DEPTH))
        ras_cnt <= ras_cnt + CNT_W'(1);
    end else if (ras_do_pop && !ras_do_push) begin
      ras_ptr <= ras_ptr - PTR_W'(1);
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end
`else
  logic unused_ras;

  assign ras_hit    = 1'b0;
  assign ras_top    = '0;
  assign ras_count  = '0;
  assign unused_ras = ^{jr_ra, ras_push, req_pop};
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: expected state is queued when a step is driven
// and popped/compared after the clock edge that should produce it.
module tb_pc_fetch_ctrl;

`ifdef PC_FETCH_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pcenable;
  logic [1:0]  pcsrc;
  logic        BEQ;
  logic        zero_f;
  logic [31:0] branch_pc4;
  logic [31:0] immedEXT;
  logic [25:0] jaddr;
  logic [31:0] rdat1;
  logic        jr_ra;
  logic        ras_push;
  logic [31:0] pcout;
  logic [31:0] pcplus4;
  logic        redirect;
  logic        pend_valid;
  logic        misalign;
  logic [2:0]  ras_count;

  pc_fetch_ctrl #(.PC_W(32), .RESET_PC(32'h0000_0100), .RAS_DEPTH(4)) dut (
    .CLK(CLK), .nRST(nRST), .pcenable(pcenable), .pcsrc(pcsrc), .BEQ(BEQ),
    .zero_f(zero_f), .branch_pc4(branch_pc4), .immedEXT(immedEXT), .jaddr(jaddr),
    .rdat1(rdat1), .jr_ra(jr_ra), .ras_push(ras_push), .pcout(pcout),
    .pcplus4(pcplus4), .redirect(redirect), .pend_valid(pend_valid),
    .misalign(misalign), .ras_count(ras_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        rd;
    logic        pv;
    logic        ms;
    logic [2:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(string tag, logic [31:0] pc, logic rd, logic pv, logic ms, logic [2:0] cnt);
    exp_t e;
    e.tag = tag; e.pc = pc; e.rd = rd; e.pv = pv; e.ms = ms; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".pcout"},     pcout,             e.pc);
      cmp({e.tag, ".pcplus4"},   pcplus4,           e.pc + 32'd4);
      cmp({e.tag, ".redirect"},  {31'd0, redirect}, {31'd0, e.rd});
      cmp({e.tag, ".pend"},      {31'd0, pend_valid}, {31'd0, e.pv});
      cmp({e.tag, ".misalign"},  {31'd0, misalign}, {31'd0, e.ms});
      cmp({e.tag, ".ras_count"}, {29'd0, ras_count}, {29'd0, e.cnt});
    end
  endtask

  task automatic step(string tag, logic [31:0] pc, logic rd, logic pv, logic ms, logic [2:0] cnt);
    expect_state(tag, pc, rd, pv, ms, cnt);
    @(posedge CLK);
    #1;
    check_now();
  endtask

  logic [31:0] pops [4];

  initial begin
    nRST = 1'b1; pcenable = 1'b0; pcsrc = 2'b00; BEQ = 1'b0; zero_f = 1'b0;
    branch_pc4 = '0; immedEXT = '0; jaddr = '0; rdat1 = '0; jr_ra = 1'b0; ras_push = 1'b0;
    pops[0] = 32'h50; pops[1] = 32'h40; pops[2] = 32'h30; pops[3] = 32'h20;

    #2 nRST = 1'b0;
    #1;
    expect_state("reset", 32'h100, 1'b0, 1'b0, 1'b0, 3'd0);
    check_now();
    @(posedge CLK);
    #1 nRST = 1'b1;

    // Sequential fetch
    pcenable = 1'b1; pcsrc = 2'b00;
    step("seq0", 32'h104, 1'b0, 1'b0, 1'b0, 3'd0);
    step("seq1", 32'h108, 1'b0, 1'b0, 1'b0, 3'd0);
    step("seq2", 32'h10C, 1'b0, 1'b0, 1'b0, 3'd0);

    // Branch resolution
    pcsrc = 2'b01; rdat1 = 32'h200;
    step("jr200", 32'h200, 1'b1, 1'b0, 1'b0, 3'd0);
    pcsrc = 2'b10; BEQ = 1'b1; zero_f = 1'b1; branch_pc4 = 32'h1F8; immedEXT = 32'hFFFF_FFFE;
    step("beq_taken", 32'h1F0, 1'b1, 1'b0, 1'b0, 3'd0);
    pcsrc = 2'b00;
    step("beq_pulse_end", 32'h1F4, 1'b0, 1'b0, 1'b0, 3'd0);
    pcsrc = 2'b01; rdat1 = 32'h200;
    step("jr200b", 32'h200, 1'b1, 1'b0, 1'b0, 3'd0);
    pcsrc = 2'b10; BEQ = 1'b0; zero_f = 1'b1;
    step("bne_not_taken", 32'h204, 1'b0, 1'b0, 1'b0, 3'd0);
    zero_f = 1'b0;
    step("bne_taken", 32'h1F0, 1'b1, 1'b0, 1'b0, 3'd0);
    BEQ = 1'b1;
    step("beq_not_taken", 32'h1F4, 1'b0, 1'b0, 1'b0, 3'd0);

    // Stall with a latched redirect
    pcenable = 1'b0; pcsrc = 2'b00;
    step("stall_idle", 32'h1F4, 1'b0, 1'b0, 1'b0, 3'd0);
    pcsrc = 2'b01; rdat1 = 32'h4000;
    step("stall_jr0", 32'h1F4, 1'b0, 1'b1, 1'b0, 3'd0);
    step("stall_jr1", 32'h1F4, 1'b0, 1'b1, 1'b0, 3'd0);
    pcenable = 1'b1; pcsrc = 2'b00;
    step("pend_apply", 32'h4000, 1'b1, 1'b0, 1'b0, 3'd0);
    pcenable = 1'b0; pcsrc = 2'b11; jaddr = 26'h000_0040;
    step("stall_j", 32'h4000, 1'b0, 1'b1, 1'b0, 3'd0);
    pcsrc = 2'b01; rdat1 = 32'h6000;
    step("stall_latest", 32'h4000, 1'b0, 1'b1, 1'b0, 3'd0);
    pcenable = 1'b1; pcsrc = 2'b11;
    step("pend_wins", 32'h6000, 1'b1, 1'b0, 1'b0, 3'd0);
    pcsrc = 2'b00;
    step("after_pend", 32'h6004, 1'b0, 1'b0, 1'b0, 3'd0);

    // Jump and misalignment
    pcsrc = 2'b01; rdat1 = 32'h1000_0000;
    step("jr_hi", 32'h1000_0000, 1'b1, 1'b0, 1'b0, 3'd0);
    pcsrc = 2'b11; jaddr = 26'h000_0040;
    step("jump", 32'h1000_0100, 1'b1, 1'b0, 1'b0, 3'd0);
    pcsrc = 2'b01; rdat1 = 32'h0000_0203;
    step("jr_misalign", 32'h200, 1'b1, 1'b0, 1'b1, 3'd0);
    pcsrc = 2'b00;
    step("misalign_sticky", 32'h204, 1'b0, 1'b0, 1'b1, 3'd0);

    // Wrap at the top of the address space
    pcsrc = 2'b01; rdat1 = 32'hFFFF_FFFC;
    step("jr_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 3'd0);
    pcsrc = 2'b00;
    step("wrap", 32'h0, 1'b0, 1'b0, 1'b1, 3'd0);

    // Return-address stack: five pushes into a depth-4 stack, then pops
    pcsrc = 2'b11; jaddr = 26'h000_0100; ras_push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      branch_pc4 = 32'h10 * (i + 1);
      step($sformatf("jal%0d", i), 32'h400, 1'b1, 1'b0, 1'b1,
           RAS_ON ? ((i < 4) ? 3'(i + 1) : 3'd4) : 3'd0);
    end
    ras_push = 1'b0; pcsrc = 2'b01; jr_ra = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rdat1 = 32'hA00 + 32'h10 * i;
      step($sformatf("jr_ra%0d", i), RAS_ON ? pops[i] : rdat1, 1'b1, 1'b0, 1'b1,
           RAS_ON ? 3'(3 - i) : 3'd0);
    end
    rdat1 = 32'h99C;
    step("jr_ra_underflow", 32'h99C, 1'b1, 1'b0, 1'b1, 3'd0);

    // RAS prediction latched during a stall pops when applied
    jr_ra = 1'b0; pcsrc = 2'b11; ras_push = 1'b1; branch_pc4 = 32'h70;
    step("jal_70", 32'h400, 1'b1, 1'b0, 1'b1, RAS_ON ? 3'd1 : 3'd0);
    ras_push = 1'b0; pcenable = 1'b0; pcsrc = 2'b01; jr_ra = 1'b1; rdat1 = 32'hB00;
    step("stall_jr_ra", 32'h400, 1'b0, 1'b1, 1'b1, RAS_ON ? 3'd1 : 3'd0);
    pcenable = 1'b1; pcsrc = 2'b00; jr_ra = 1'b0;
    step("pend_ras_apply", RAS_ON ? 32'h70 : 32'hB00, 1'b1, 1'b0, 1'b1, 3'd0);

    // Asynchronous reset while a redirect is pending
    pcsrc = 2'b11; ras_push = 1'b1; branch_pc4 = 32'h80;
    step("jal_80", 32'h400, 1'b1, 1'b0, 1'b1, RAS_ON ? 3'd1 : 3'd0);
    ras_push = 1'b0; pcenable = 1'b0; pcsrc = 2'b01; rdat1 = 32'h7000;
    step("stall_pre_reset", 32'h400, 1'b0, 1'b1, 1'b1, RAS_ON ? 3'd1 : 3'd0);
    #2 nRST = 1'b0;
    #1;
    expect_state("async_reset", 32'h100, 1'b0, 1'b0, 1'b0, 3'd0);
    check_now();
    nRST = 1'b1;
    pcenable = 1'b1; pcsrc = 2'b00;
    step("post_reset", 32'h104, 1'b0, 1'b0, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
